// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit: access size codes, FSM state
// encoding and the byte count of each access size.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    // Number of bytes touched by an access of the given size (0 for the illegal code).
    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational byte-lane steering for a 4-byte memory row: store byte
// enables and replicated write data, load extraction with sign/zero extension,
// and alignment / size legality flags.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      offset,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    input  logic [31:0]     rd_row,
    output logic [3:0]      byte_en,
    output logic [31:0]     wr_row,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic            illegal_size
);

    logic [31:0] wdata32;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext32;

    // Lane selection and extension; every legal access lies inside one row.
    always_comb begin
        wdata32      = 32'(wdata);
        rd_byte      = 8'(rd_row >> {offset, 3'b000});
        rd_half      = offset[1] ? rd_row[31:16] : rd_row[15:0];
        byte_en      = 4'b0000;
        wr_row       = wdata32;
        ext32        = 32'd0;
        misaligned   = 1'b0;
        illegal_size = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << offset;
                wr_row  = {4{wdata32[7:0]}};
                ext32   = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                misaligned = offset[0];
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                wr_row     = {2{wdata32[15:0]}};
                ext32      = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            SZ_WORD: begin
                misaligned   = |offset;
                illegal_size = (XLEN < 32);
                byte_en      = 4'b1111;
                wr_row       = wdata32;
                ext32        = rd_row;
            end
            default: begin
                illegal_size = 1'b1;
            end
        endcase
        load_data = ext32[XLEN-1:0];
    end

endmodule

// File: rtl/dmem_unit.sv
// Byte-addressable data memory for the MEM stage. A request is latched in IDLE,
// optionally delayed by WAIT_STATES cycles, executed in EXEC and answered with
// a one-cycle resp_valid strobe in RESP. Faulting accesses never write memory.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    // Memory is organised as DEPTH/4 rows of four byte lanes.
    localparam int ROWS = DEPTH / 4;
    localparam int RW   = $clog2(ROWS);
    localparam logic [3:0]      WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic              accept;

    logic              lat_we_reg;
    logic [1:0]        lat_size_reg;
    logic              lat_uns_reg;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic [XLEN-1:0]   lat_wdata_reg;

    logic [XLEN-1:0]   resp_rdata_reg;
    logic              resp_err_reg;

    logic [3:0]        byte_en;
    logic [31:0]       wr_row;
    logic [31:0]       rd_row;
    logic [XLEN-1:0]   load_data;
    logic              misaligned;
    logic              illegal_size;
    logic [ADDR_W:0]   end_addr;
    logic              range_err;
    logic              access_err;
    logic [3:0]        wr_en;
    logic [RW-1:0]     wr_idx;
    logic [RW-1:0]     rd_idx;

    dmem_align #(.XLEN(XLEN)) u_align (
        .size         (lat_size_reg),
        .offset       (lat_addr_reg[1:0]),
        .is_unsigned  (lat_uns_reg),
        .wdata        (lat_wdata_reg),
        .rd_row       (rd_row),
        .byte_en      (byte_en),
        .wr_row       (wr_row),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .illegal_size (illegal_size)
    );

    // Next-state logic: accept in IDLE, count down wait states, then execute and respond.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        accept        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end else begin
                        state_next = EXEC;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = EXEC;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Request capture; the latched copy drives all later checks and the access itself.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            lat_we_reg    <= req_we;
            lat_size_reg  <= req_size;
            lat_uns_reg   <= req_unsigned;
            lat_addr_reg  <= req_addr;
            lat_wdata_reg <= req_wdata;
        end
    end

    // Fault detection and per-lane write enables for the EXEC edge.
    always_comb begin
        end_addr   = {1'b0, lat_addr_reg} + {{(ADDR_W - 2){1'b0}}, bytes_of(lat_size_reg)};
        range_err  = (end_addr > DEPTH_L);
        access_err = misaligned | illegal_size | range_err;
        wr_en      = (state_reg == EXEC && lat_we_reg && !access_err && !reset) ? byte_en : 4'b0000;
        wr_idx     = lat_addr_reg[RW+1:2];
        // Read the incoming request's row during IDLE so that the row is ready
        // in EXEC even when there are no wait states.
        rd_idx     = (state_reg == IDLE) ? req_addr[RW+1:2] : lat_addr_reg[RW+1:2];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] bank [ROWS];
            logic [7:0] rd_lane_reg;

            // One byte lane of the memory with a registered read port.
            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    bank[wr_idx] <= wr_row[8*gi +: 8];
                end
                rd_lane_reg <= bank[rd_idx];
            end

            assign rd_row[8*gi +: 8] = rd_lane_reg;
        end
    endgenerate

    // Response registers, loaded at the EXEC edge and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else if (state_reg == EXEC) begin
            resp_err_reg   <= access_err;
            resp_rdata_reg <= (access_err || lat_we_reg) ? '0 : load_data;
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_dmem_unit.sv
// Testbench for dmem_unit: one instance without wait states and one with three,
// driven by directed and random accesses and checked against a byte-array model.
module tb_dmem_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset        [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];

    logic [7:0] mdl [2][256];
    int total = 0;
    int bad   = 0;

    dmem_unit #(.XLEN(32), .DEPTH(256), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_unit #(.XLEN(32), .DEPTH(256), .ADDR_W(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte array, little-endian, with the fault rules applied first.
    task automatic model_access(input int d, input bit we, input bit [1:0] size, input bit uns,
                                input bit [31:0] addr, input bit [31:0] wdata,
                                output bit [31:0] rd, output bit err);
        int n;
        longint val;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        err = (n == 0);
        if (!err && (addr % n) != 0) err = 1'b1;
        if (!err && (longint'(addr) + n) > 256) err = 1'b1;
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mdl[d][addr + i] = wdata[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < n; i++) val = val | (longint'(mdl[d][addr + i]) << (8 * i));
                if (!uns && n < 4 && val[8*n-1]) val = val - (longint'(1) << (8 * n));
                rd = val[31:0];
            end
        end
    endtask

    // One full handshake. Entered at a negedge, returns at the negedge after RESP.
    // With keep set, req_valid stays high while the unit is busy.
    task automatic txn(input int d, input bit we, input bit [1:0] size, input bit uns,
                       input bit [31:0] addr, input bit [31:0] wdata, input bit keep,
                       output logic [31:0] got_rd, output logic got_err);
        int w;
        int waited;
        int first_k;
        int pulses;
        bit [31:0] exp_rd;
        bit exp_err;
        w       = (d == 0) ? 0 : 3;
        got_rd  = 32'hx;
        got_err = 1'bx;
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        req_valid[d]    = 1'b1;
        waited = 0;
        while (req_ready[d] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 32'(req_ready[d]), 32'd1);
        if (req_ready[d] !== 1'b1) begin
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        model_access(d, we, size, uns, addr, wdata, exp_rd, exp_err);
        first_k = 0;
        pulses  = 0;
        for (int k = 1; k <= w + 3; k++) begin
            @(negedge clk);
            if (k == 1 && !keep) req_valid[d] = 1'b0;
            if (k <= w + 2) check("busy_ready", 32'(req_ready[d]), 32'd0);
            if (resp_valid[d] === 1'b1) begin
                pulses++;
                if (first_k == 0) begin
                    first_k = k;
                    got_rd  = resp_rdata[d];
                    got_err = resp_err[d];
                end
            end
        end
        check("latency", 32'(first_k), 32'(w + 2));
        check("resp_count", 32'(pulses), 32'd1);
        check("rdata", got_rd, exp_rd);
        check("err", 32'(got_err), 32'(exp_err));
        check("rdata_hold", resp_rdata[d], exp_rd);
        check("ready_after", 32'(req_ready[d]), 32'd1);
        $display("txn dut=%0d we=%0d size=%0d uns=%0d addr=0x%0h wdata=0x%08h -> rdata=0x%08h err=%0d",
                 d, we, size, uns, addr, wdata, got_rd, got_err);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          pulses;
        bit [1:0]    sz;
        bit [31:0]   ad;

        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
            req_unsigned[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", 32'(req_ready[d]), 32'd1);
            check("reset_valid", 32'(resp_valid[d]), 32'd0);
            check("reset_rdata", resp_rdata[d], 32'd0);
            check("reset_err", 32'(resp_err[d]), 32'd0);
        end

        // Known contents everywhere so every later load has a defined expectation.
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 64; a++)
                txn(d, 1'b1, 2'd2, 1'b0, 32'(a * 4), $urandom, 1'b0, rd, er);

        // Word store and lane ordering.
        txn(0, 1'b1, 2'd2, 1'b0, 32'd12, 32'hF1F4F5F6, 1'b0, rd, er);
        check("sw12_err", 32'(er), 32'd0);
        txn(0, 1'b0, 2'd2, 1'b0, 32'd12, 32'd0, 1'b0, rd, er);
        check("lw12", rd, 32'hF1F4F5F6);
        txn(0, 1'b0, 2'd0, 1'b1, 32'd12, 32'd0, 1'b0, rd, er);
        check("lbu12", rd, 32'h000000F6);

        // Byte store and load extension.
        txn(0, 1'b1, 2'd0, 1'b0, 32'd13, 32'h000000AA, 1'b0, rd, er);
        txn(0, 1'b0, 2'd0, 1'b0, 32'd13, 32'd0, 1'b0, rd, er);
        check("lb13", rd, 32'hFFFFFFAA);
        txn(0, 1'b0, 2'd0, 1'b1, 32'd13, 32'd0, 1'b0, rd, er);
        check("lbu13", rd, 32'h000000AA);
        txn(0, 1'b0, 2'd1, 1'b0, 32'd12, 32'd0, 1'b0, rd, er);
        check("lh12", rd, 32'hFFFFAAF6);
        txn(0, 1'b0, 2'd1, 1'b1, 32'd14, 32'd0, 1'b0, rd, er);
        check("lhu14", rd, 32'h0000F1F4);

        // Misaligned and illegal-size accesses.
        txn(0, 1'b1, 2'd1, 1'b0, 32'd13, 32'h0000BEEF, 1'b0, rd, er);
        check("sh13_err", 32'(er), 32'd1);
        txn(0, 1'b0, 2'd2, 1'b0, 32'd14, 32'd0, 1'b0, rd, er);
        check("lw14_err", 32'(er), 32'd1);
        check("lw14_rdata", rd, 32'd0);
        txn(0, 1'b1, 2'd3, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, rd, er);
        check("sz3_err", 32'(er), 32'd1);

        // Range boundary.
        txn(0, 1'b1, 2'd2, 1'b0, 32'd252, 32'h0BADCAFE, 1'b0, rd, er);
        check("sw252_err", 32'(er), 32'd0);
        txn(0, 1'b1, 2'd2, 1'b0, 32'd254, 32'h11111111, 1'b0, rd, er);
        check("sw254_err", 32'(er), 32'd1);
        txn(0, 1'b1, 2'd0, 1'b0, 32'd256, 32'h00000022, 1'b0, rd, er);
        check("sb256_err", 32'(er), 32'd1);
        txn(0, 1'b0, 2'd2, 1'b0, 32'd252, 32'd0, 1'b0, rd, er);
        check("lw252", rd, 32'h0BADCAFE);

        // Full dump: faulting stores must have left every byte untouched.
        for (int a = 0; a < 64; a++)
            txn(0, 1'b0, 2'd2, 1'b0, 32'(a * 4), 32'd0, 1'b0, rd, er);

        // Random traffic, back-to-back on the wait-state instance.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                sz = 2'($urandom_range(0, 3));
                ad = 32'($urandom_range(0, 259));
                if ($urandom_range(0, 1) == 1) ad = (sz == 2'd1) ? (ad & ~32'd1) :
                                                   (sz == 2'd2) ? (ad & ~32'd3) : ad;
                txn(d, 1'(($urandom % 2)), sz, 1'(($urandom % 2)), ad, $urandom, (d == 1), rd, er);
            end
            req_valid[d] = 1'b0;
        end

        // Reset while a store sits in WAIT.
        txn(1, 1'b1, 2'd2, 1'b0, 32'd0, 32'hCAFEF00D, 1'b0, rd, er);
        txn(1, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, rd, er);
        check("pre_rst_lw0", rd, 32'hCAFEF00D);
        req_we[1] = 1'b1; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
        req_addr[1] = 32'd0; req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
        check("rst_pre_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("rst_in_wait", 32'(req_ready[1]), 32'd0);
        reset[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset[1] = 1'b0;
        check("rst_ready", 32'(req_ready[1]), 32'd1);
        check("rst_valid", 32'(resp_valid[1]), 32'd0);
        check("rst_rdata", resp_rdata[1], 32'd0);
        check("rst_err", 32'(resp_err[1]), 32'd0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid[1] !== 1'b0) pulses++;
        end
        check("rst_no_resp", 32'(pulses), 32'd0);
        txn(1, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, rd, er);
        check("rst_mem0", rd, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_unit.md
Name: dmem_unit

Overview:
- Parametrised, byte-addressable data memory unit for the pipelined core's MEM stage.
- Generalises the fixed word-store path: sb/sh/sw stores and lb/lbu/lh/lhu/lw loads, little-endian byte lanes.
- Configurable size and wait-state latency, behind a valid/ready request and response handshake.
- Flags misaligned, illegal-size and out-of-range accesses instead of corrupting memory.

Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8, max 32 (size codes cover byte/half/word).
- DEPTH, 256, memory size in bytes; power of two.
- ADDR_W, 32, request address width.
- WAIT_STATES, 0, extra cycles inserted between acceptance and execution; range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data; low bytes used for byte/half.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  XLEN  load result; 0 for stores and errors.
- resp_err  out  1  access faulted; valid with resp_valid.

Behaviour:
- Reset:
  - Synchronous, active-high; state goes to IDLE, wait counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0; req_ready = 1 from the cycle after reset.
  - Memory array is NOT cleared by reset.
- FSM states: IDLE, WAIT, EXEC, RESP.
  - IDLE: req_ready = 1. On req_valid & req_ready, latch we/size/unsigned/addr/wdata. Go to WAIT if WAIT_STATES > 0, else EXEC.
  - WAIT: counter loads WAIT_STATES-1 on entry and decrements each cycle. Go to EXEC when the counter reaches 0.
  - EXEC: perform the access at the closing edge.
    - Store: write only the enabled byte lanes.
    - Load: register assembled, extended data into resp_rdata.
    - Next state RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. The next request can be accepted one cycle after RESP.
- Latency: request accepted at edge N -> resp_valid high in cycle N+2+WAIT_STATES.
- Throughput: one access per 3+WAIT_STATES cycles.
- Byte lanes, little-endian:
  - Word store at address A: mem[A] = wdata[7:0], mem[A+1] = wdata[15:8], mem[A+2] = wdata[23:16], mem[A+3] = wdata[31:24].
  - Half and byte stores use the low 2 bytes / 1 byte of wdata.
- Load extension: lb/lh replicate the top loaded bit up to XLEN; lbu/lhu zero-fill.
- Errors: resp_err = 1, no memory write, resp_rdata = 0, in any of these cases:
  - half access with addr[0] != 0;
  - word access with addr[1:0] != 0;
  - size = 3;
  - addr + access_bytes > DEPTH.
- Error checks use the latched address, so the full handshake timing is kept even on a fault.
- resp_rdata and resp_err hold their values until the next RESP; only resp_valid qualifies them.
- req_* inputs are ignored outside IDLE; a request held valid while busy is accepted on the next IDLE cycle.
- Reset mid-operation (WAIT/EXEC/RESP): the transaction is abandoned and no write occurs unless the EXEC edge has already passed. No response is issued.

Decomposition:
- Package dmem_pkg holds:
  - size codes SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2;
  - FSM state encoding (IDLE/WAIT/EXEC/RESP);
  - function bytes_of(size).
- Sub-module dmem_align, purely combinational, computes:
  - byte enables and lane-shifted write data from size/addr/wdata;
  - extracted, extended load data from raw bytes;
  - misalignment and illegal-size flags.
- dmem_unit keeps the FSM, wait counter, range check and memory array.

Test Plan:
- WAIT_STATES = 0, sw of 0xF1F4F5F6 at addr 12 -> resp_valid two cycles after acceptance, resp_err = 0; mem[12..15] = F6, F5, F4, F1; lw at 12 returns 0xF1F4F5F6.
- After the above, sb 0x000000AA at 13 then lb/lbu at 13 -> 0xFFFFFFAA / 0x000000AA; lh at 12 -> 0xFFFFAAF6; mem[14..15] unchanged.
- sh at 13, lw at 14, and size = 3 at 0 -> each returns resp_err = 1, resp_rdata = 0; memory dump identical before and after.
- DEPTH = 256: sw at 252 succeeds; sw at 254 and sb at 256 give resp_err = 1 with no write.
- WAIT_STATES = 3, back-to-back req_valid held high -> resp_valid in cycle N+5; req_ready low for 5 cycles after each acceptance; exactly one response per request.
- reset asserted for one cycle while in WAIT during a store of 0x12345678 at 0 -> no resp_valid, mem[0..3] unchanged, req_ready = 1 the following cycle, outputs at reset values.
